// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_fsm
// Brief    : RV32 multi-cycle main controller (FETCH/DECODE/EXEC/MEM/WB) with
//            shared memory port handshake, timeout trap and optional perf
//            counters enabled by defining MCTRL_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  mem_to_reg,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        trap,
  output logic [2:0]  state_o
`ifdef MCTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB_ALU = 3'd5,
    S_WB_MEM = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_LD   = 7'b0000011;
  localparam logic [6:0] c_OP_ST   = 7'b0100011;
  localparam logic [6:0] c_OP_BR   = 7'b1100011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [6:0] c_OP_JALR = 7'b1100111;

  // Counter only has to reach MEM_TIMEOUT-1: the wait cycle that would reach
  // MEM_TIMEOUT is the one that redirects to TRAP.
  localparam int              c_CW       = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(MEM_TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic [6:0]      r_op;
  logic [c_CW-1:0] r_cnt;
  logic            r_trap;

  logic            w_mem_req;
  logic            w_mem_we;
  logic            w_iord;
  logic            w_ir_write;
  logic            w_pc_write;
  logic [1:0]      w_pc_src;
  logic            w_reg_write;
  logic [1:0]      w_mem_to_reg;
  logic            w_alu_src_b;
  logic [1:0]      w_alu_op;

  always_comb begin
    w_next       = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 2'd0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 2'd0;
    w_alu_src_b  = 1'b0;
    w_alu_op     = 2'b00;

    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end

      S_DECODE: begin
        case (opcode)
          c_OP_R, c_OP_I, c_OP_LD, c_OP_ST,
          c_OP_BR, c_OP_JAL, c_OP_JALR: w_next = S_EXEC;
          default:                      w_next = S_TRAP;
        endcase
      end

      S_EXEC: begin
        case (r_op)
          c_OP_R: begin
            w_alu_op = 2'b10;
            w_next   = S_WB_ALU;
          end
          c_OP_I: begin
            w_alu_src_b = 1'b1;
            w_alu_op    = 2'b10;
            w_next      = S_WB_ALU;
          end
          c_OP_LD: begin
            w_alu_src_b = 1'b1;
            w_next      = S_MEM_RD;
          end
          c_OP_ST: begin
            w_alu_src_b = 1'b1;
            w_next      = S_MEM_WR;
          end
          c_OP_BR: begin
            w_alu_op   = 2'b01;
            w_pc_write = branch_taken;
            w_pc_src   = 2'd1;
            w_next     = S_FETCH;
          end
          c_OP_JAL: begin
            w_pc_write   = 1'b1;
            w_pc_src     = 2'd1;
            w_reg_write  = 1'b1;
            w_mem_to_reg = 2'd2;
            w_alu_op     = 2'b11;
            w_next       = S_FETCH;
          end
          c_OP_JALR: begin
            w_pc_write   = 1'b1;
            w_pc_src     = 2'd2;
            w_reg_write  = 1'b1;
            w_mem_to_reg = 2'd2;
            w_alu_src_b  = 1'b1;
            w_alu_op     = 2'b11;
            w_next       = S_FETCH;
          end
          default: w_next = S_TRAP;
        endcase
      end

      S_MEM_RD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        if (mem_ready) w_next = S_WB_MEM;
      end

      S_MEM_WR: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        w_iord    = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end

      S_WB_ALU: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end

      S_WB_MEM: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 2'd1;
        w_next       = S_FETCH;
      end

      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase

    // A ready in the final allowed wait cycle still completes normally.
    if (w_mem_req && !mem_ready && (r_cnt == c_CNT_LAST)) w_next = S_TRAP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_op        <= 7'd0;
      r_cnt       <= '0;
      r_trap      <= 1'b0;
`ifdef MCTRL_PERF_CNT_EN
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= opcode;
      if ((w_next != r_state) || !w_mem_req || mem_ready) r_cnt <= '0;
      else                                                 r_cnt <= r_cnt + 1'b1;
      if (w_next == S_TRAP) r_trap <= 1'b1;
`ifdef MCTRL_PERF_CNT_EN
      if (r_state != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if ((w_next == S_FETCH) &&
          ((r_state == S_EXEC) || (r_state == S_WB_ALU) ||
           (r_state == S_WB_MEM) || (r_state == S_MEM_WR)))
        instret_cnt <= instret_cnt + 32'd1;
`endif
    end
  end

  // Strobes are forced low for the whole reset assertion, not just after an edge.
  assign mem_req    = w_mem_req   & ~reset;
  assign mem_we     = w_mem_we    & ~reset;
  assign iord       = w_iord      & ~reset;
  assign ir_write   = w_ir_write  & ~reset;
  assign pc_write   = w_pc_write  & ~reset;
  assign reg_write  = w_reg_write & ~reset;
  assign alu_src_b  = w_alu_src_b & ~reset;
  assign pc_src     = reset ? 2'd0 : w_pc_src;
  assign mem_to_reg = reset ? 2'd0 : w_mem_to_reg;
  assign alu_op     = reset ? 2'd0 : w_alu_op;
  assign trap       = r_trap;
  assign state_o    = r_state;

endmodule
`default_nettype wire
